mfu_brick_seq: RTL and testbench
================================

MFU_BRICK_SEQ -- requirements
Module: mfu_brick_seq

Interface
REQ-001 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-002 nrst  input  1  reset; synchronous, active-low.
REQ-003 in_valid  input  1  operand request valid.
REQ-004 in_ready  output  1  block accepts request; high only in IDLE.
REQ-005 op_a  input  8  multiplicand; low 2N bits used.
REQ-006 op_b  input  8  multiplier; low 2N bits used.
REQ-007 a_signed  input  1  op_a is two's complement.
REQ-008 b_signed  input  1  op_b is two's complement.
REQ-009 prec  input  2  operand width: 0=2-bit (N=1), 1=4-bit (N=2), 2=8-bit (N=4), 3 treated as 8-bit.
REQ-010 bb_en  output  1  brick multiplier enable.
REQ-011 bb_a  output  2  current a brick.
REQ-012 bb_b  output  2  current b brick.
REQ-013 bb_sel  output  2  brick signedness: [1]=a brick signed, [0]=b brick signed.
REQ-014 bb_p  input  4  brick product returned combinationally in the same cycle as bb_a/bb_b.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 result  output  16  signed/unsigned product, width-extended to 16 bits.

Function
REQ-018 States IDLE, RUN, DONE; in_ready=1 iff IDLE.
REQ-019 IDLE: on in_valid&&in_ready, capture op_a, op_b, a_signed, b_signed, N; clear accumulator and brick counter k; go to RUN.
REQ-020 RUN lasts exactly N*N cycles (1, 4 or 16); k counts 0..N*N-1, one increment per cycle.
REQ-021 Brick indices: i=k/N (a brick), j=k mod N (b brick); bb_a=a[2i+1:2i], bb_b=b[2j+1:2j].
REQ-022 bb_sel[1]=a_signed&&(i==N-1); bb_sel[0]=b_signed&&(j==N-1).
REQ-023 bb_en=1 every RUN cycle; bb_en=0, bb_a=0, bb_b=0, bb_sel=0 in IDLE and DONE.
REQ-024 Each RUN cycle: acc += ext(bb_p) << 2*(i+j), 16-bit modular add. ext() sign-extends if either bb_sel bit is 1, else zero-extends.
REQ-025 After the cycle with k=N*N-1, go to DONE; out_valid=1 on the next cycle; result=acc.
REQ-026 Latency: accept edge to out_valid = N*N+1 cycles.
REQ-027 DONE: hold out_valid and result stable while out_ready=0; on out_valid&&out_ready return to IDLE, out_valid drops next cycle.
REQ-028 No new request accepted in RUN or DONE; in_valid ignored there.
REQ-029 Bits of op_a/op_b above 2N ignored; result equals exact product for the declared width and signedness. For 2-bit and 4-bit modes, result is sign- or zero-extended to 16 bits per the operand signedness.
REQ-030 result holds last value in IDLE until the next completion.

Reset
REQ-031 nrst=0 at a clk edge: state=IDLE, k=0, acc=0, result=0, out_valid=0, bb_en=0, bb_a/bb_b/bb_sel=0. in_ready=1 from the first cycle with nrst=1.
REQ-032 Reset in RUN or DONE aborts the operation; no out_valid for that request; pending result discarded.

Verification
REQ-033 prec=2, unsigned, a=0xFF, b=0xFF -> 16 bb_en cycles; out_valid at cycle 17; result=0xFE01.
REQ-034 prec=2, signed both, a=0x80, b=0x80 -> result=0x4000. a=0x80, b=0x7F -> result=0xC080 (-16256).
REQ-035 prec=0, signed both, a=2'b10, b=2'b10 -> 1 RUN cycle with bb_sel=2'b11; result=0x0004.
REQ-036 prec=1, a_signed=1, b_signed=0, a=0x8, b=0xF -> 4 RUN cycles; result=0xFF88 (-120). Upper op bits set to 1 do not change result.
REQ-037 Hold out_ready=0 for 5 cycles after out_valid -> result, out_valid stable; in_ready=0; in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle.
REQ-038 nrst=0 at k=7 of an 8-bit op -> next cycle IDLE, acc=0, bb_en=0, no out_valid. A fresh request then completes correctly.

Source files
------------

// File: rtl/mfu_brick_seq_if.sv
// Request/response handshake and brick-multiplier
// bus for the sequential 2-bit brick multiplier.
interface mfu_brick_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        a_signed;
  logic        b_signed;
  logic [1:0]  prec;
  logic        bb_en;
  logic [1:0]  bb_a;
  logic [1:0]  bb_b;
  logic [1:0]  bb_sel;
  logic [3:0]  bb_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  a_signed,
    input  b_signed,
    input  prec,
    input  bb_p,
    input  out_ready,
    output in_ready,
    output bb_en,
    output bb_a,
    output bb_b,
    output bb_sel,
    output out_valid,
    output result
  );

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output a_signed,
    output b_signed,
    output prec,
    output bb_p,
    output out_ready,
    input  in_ready,
    input  bb_en,
    input  bb_a,
    input  bb_b,
    input  bb_sel,
    input  out_valid,
    input  result
  );
endinterface

// File: rtl/mfu_brick_seq.sv
// Sequential multiplier built from one 2x2 brick:
// walks N*N brick pairs and accumulates shifted partials.
module mfu_brick_seq (
  input logic clk,
  input logic nrst,
  mfu_brick_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        as_q, as_d;
  logic        bs_q, bs_d;
  logic [1:0]  pw_q, pw_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] res_q, res_d;

  logic [1:0]  bi, bj, ntop;
  logic [3:0]  kmax;
  logic [1:0]  a_brk, b_brk, sel;
  logic [2:0]  sh;
  logic [15:0] p16, term, acc_sum;
  logic        run;

  // Split k into a/b brick indices for the captured width
  always_comb begin
    bi   = 2'd0;
    bj   = 2'd0;
    ntop = 2'd0;
    kmax = 4'd0;
    unique case (pw_q)
      2'd0: begin
        bi   = 2'd0;
        bj   = 2'd0;
        ntop = 2'd0;
        kmax = 4'd0;
      end
      2'd1: begin
        bi   = {1'b0, k_q[1]};
        bj   = {1'b0, k_q[0]};
        ntop = 2'd1;
        kmax = 4'd3;
      end
      default: begin
        bi   = k_q[3:2];
        bj   = k_q[1:0];
        ntop = 2'd3;
        kmax = 4'd15;
      end
    endcase
  end

  // Brick operands, signedness and the shifted partial product
  always_comb begin
    a_brk   = a_q[{bi, 1'b0} +: 2];
    b_brk   = b_q[{bj, 1'b0} +: 2];
    sel     = {as_q && (bi == ntop), bs_q && (bj == ntop)};
    p16     = (|sel) ? {{12{bus.bb_p[3]}}, bus.bb_p}
                     : {12'b0, bus.bb_p};
    sh      = {1'b0, bi} + {1'b0, bj};
    term    = p16 << {sh, 1'b0};
    acc_sum = acc_q + term;
  end

  assign run = (state_q == RUN);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.bb_en     = run;
  assign bus.bb_a      = run ? a_brk : 2'b00;
  assign bus.bb_b      = run ? b_brk : 2'b00;
  assign bus.bb_sel    = run ? sel : 2'b00;

  // Next state: accept, step bricks, hold result until taken
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    as_d    = as_q;
    bs_d    = bs_q;
    pw_d    = pw_q;
    k_d     = k_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          as_d    = bus.a_signed;
          bs_d    = bus.b_signed;
          pw_d    = (bus.prec == 2'd0) ? 2'd0 :
                    (bus.prec == 2'd1) ? 2'd1 : 2'd2;
          k_d     = 4'd0;
          acc_d   = 16'd0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        acc_d = acc_sum;
        k_d   = k_q + 4'd1;
        if (k_q == kmax) begin
          res_d   = acc_sum;
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      pw_q    <= 2'd0;
      k_q     <= 4'd0;
      acc_q   <= 16'd0;
      res_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      as_q    <= as_d;
      bs_q    <= bs_d;
      pw_q    <= pw_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mfu_brick_seq.sv
// Bench for mfu_brick_seq: behavioural timeline model,
// per-cycle compare, directed literal cases and random ops.
module tb_mfu_brick_seq;

  logic clk;
  logic nrst;

  mfu_brick_seq_if u_if ();

  mfu_brick_seq dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int w, input bit s);
    int x;
    x = v & ((1 << w) - 1);
    if (s && (((x >> (w - 1)) & 1) == 1)) x = x - (1 << w);
    return x;
  endfunction

  function automatic int nof(input int p);
    return (p == 0) ? 1 : (p == 1) ? 2 : 4;
  endfunction

  function automatic int ref_prod(input int a, input int b,
                                  input bit as, input bit bs,
                                  input int p);
    int w;
    w = 2 * nof(p);
    return (sx(a, w, as) * sx(b, w, bs)) & 16'hFFFF;
  endfunction

  function automatic logic [3:0] brick(input logic [1:0] a,
                                       input logic [1:0] b,
                                       input logic [1:0] s);
    int x, y;
    x = sx(int'(a), 2, s[1]);
    y = sx(int'(b), 2, s[0]);
    return 4'((x * y) & 15);
  endfunction

  always_comb u_if.bb_p = brick(u_if.bb_a, u_if.bb_b, u_if.bb_sel);

  // Behavioural model: operation timeline counted from accept
  bit busy = 1'b0;
  int since = 0;
  int mn = 1;
  int mn2 = 1;
  int ma = 0;
  int mb = 0;
  bit mas = 1'b0;
  bit mbs = 1'b0;
  int mp = 0;
  int exp_last = 0;

  always @(posedge clk) begin
    if (!nrst) begin
      busy     = 1'b0;
      exp_last = 0;
    end else if (!busy) begin
      if (u_if.in_valid) begin
        busy  = 1'b1;
        since = 0;
        ma    = int'(u_if.op_a);
        mb    = int'(u_if.op_b);
        mas   = u_if.a_signed;
        mbs   = u_if.b_signed;
        mp    = int'(u_if.prec);
        mn    = nof(mp);
        mn2   = mn * mn;
      end
    end else if (since < mn2) begin
      since++;
      if (since == mn2) exp_last = ref_prod(ma, mb, mas, mbs, mp);
    end else if (u_if.out_ready) begin
      busy = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (nrst) begin
      bit erun, edone;
      int i, j;
      erun  = busy && (since < mn2);
      edone = busy && (since >= mn2);
      chk("in_ready", int'(u_if.in_ready), int'(!busy));
      chk("bb_en", int'(u_if.bb_en), int'(erun));
      chk("out_valid", int'(u_if.out_valid), int'(edone));
      chk("result", int'(u_if.result), exp_last);
      if (erun) begin
        i = since / mn;
        j = since % mn;
        chk("bb_a", int'(u_if.bb_a), (ma >> (2 * i)) & 3);
        chk("bb_b", int'(u_if.bb_b), (mb >> (2 * j)) & 3);
        chk("bb_sel", int'(u_if.bb_sel),
            ((mas && i == mn - 1) ? 2 : 0) +
            ((mbs && j == mn - 1) ? 1 : 0));
      end else begin
        chk("bb_idle", int'({u_if.bb_a, u_if.bb_b, u_if.bb_sel}), 0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit as, input bit bs,
                        input logic [1:0] p, input int hold,
                        input bit lit_en, input int lit,
                        input int lat, input string nm);
    int cnt;
    u_if.op_a     = a;
    u_if.op_b     = b;
    u_if.a_signed = as;
    u_if.b_signed = bs;
    u_if.prec     = p;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    cnt = 1;
    while (!u_if.out_valid && cnt < 40) begin
      u_if.in_valid = 1'($urandom_range(0, 1));
      u_if.op_a     = 8'($urandom);
      tick();
      cnt++;
    end
    if (!u_if.out_valid) begin
      chk({nm, "_timeout"}, 0, 1);
    end
    if (lit_en) begin
      chk(nm, int'(u_if.result), lit);
      chk({nm, "_lat"}, cnt, lat);
    end
    repeat (hold) begin
      u_if.in_valid = 1'($urandom_range(0, 1));
      tick();
      if (lit_en) begin
        chk({nm, "_hold_res"}, int'(u_if.result), lit);
        chk({nm, "_hold_ov"}, int'(u_if.out_valid), 1);
        chk({nm, "_hold_rdy"}, int'(u_if.in_ready), 0);
      end
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    if (lit_en) begin
      chk({nm, "_back_idle"}, int'(u_if.in_ready), 1);
      chk({nm, "_ov_drop"}, int'(u_if.out_valid), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    nrst           = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.op_a      = 8'd0;
    u_if.op_b      = 8'd0;
    u_if.a_signed  = 1'b0;
    u_if.b_signed  = 1'b0;
    u_if.prec      = 2'd0;
    u_if.out_ready = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    #1;
    chk("rst_in_ready", int'(u_if.in_ready), 1);
    chk("rst_out_valid", int'(u_if.out_valid), 0);
    chk("rst_result", int'(u_if.result), 0);
    chk("rst_bb_en", int'(u_if.bb_en), 0);

    chk("model_ff", ref_prod(8'hFF, 8'hFF, 0, 0, 2), 16'hFE01);
    chk("model_8080", ref_prod(8'h80, 8'h80, 1, 1, 2), 16'h4000);
    chk("model_807f", ref_prod(8'h80, 8'h7F, 1, 1, 2), 16'hC080);
    chk("model_2b", ref_prod(2, 2, 1, 1, 0), 16'h0004);
    chk("model_4b", ref_prod(8'hF8, 8'hFF, 1, 0, 1), 16'hFF88);

    run_op(8'hFF, 8'hFF, 0, 0, 2'd2, 0, 1, 16'hFE01, 17, "uff");
    run_op(8'h80, 8'h80, 1, 1, 2'd2, 0, 1, 16'h4000, 17, "s8080");
    run_op(8'h80, 8'h7F, 1, 1, 2'd2, 0, 1, 16'hC080, 17, "s807f");
    run_op(8'h02, 8'h02, 1, 1, 2'd0, 0, 1, 16'h0004, 2, "s2b");
    run_op(8'h08, 8'h0F, 1, 0, 2'd1, 0, 1, 16'hFF88, 5, "m4b");
    run_op(8'hF8, 8'hFF, 1, 0, 2'd1, 5, 1, 16'hFF88, 5, "m4b_up");
    run_op(8'h80, 8'h7F, 1, 1, 2'd3, 0, 1, 16'hC080, 17, "p3");

    u_if.op_a     = 8'hA5;
    u_if.op_b     = 8'h3C;
    u_if.a_signed = 1'b1;
    u_if.b_signed = 1'b0;
    u_if.prec     = 2'd2;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    repeat (7) tick();
    chk("abort_k7_en", int'(u_if.bb_en), 1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("abort_idle", int'(u_if.in_ready), 1);
    chk("abort_bb_en", int'(u_if.bb_en), 0);
    chk("abort_ov", int'(u_if.out_valid), 0);
    chk("abort_res", int'(u_if.result), 0);
    run_op(8'hFF, 8'hFF, 0, 0, 2'd2, 0, 1, 16'hFE01, 17, "post_abort");

    for (int t = 0; t < 60; t++) begin
      run_op(8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom_range(0, 3),
             0, 0, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
